// File: rtl/leaf_pkg.sv
// Shared layout for tree-scheduler leaf results: word widths, node-ID field
// and the drain FSM state encoding.
package leaf_pkg;

  localparam int RESULT_W = 42;
  localparam int ID_LSB   = 32;
  localparam int ID_W     = RESULT_W - ID_LSB;
  localparam int DEPTH    = 32;
  localparam int SLOT_W   = $clog2(DEPTH);
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  function automatic logic [ID_W-1:0] leaf_id(input logic [RESULT_W-1:0] word);
    return word[RESULT_W-1:ID_LSB];
  endfunction

  function automatic logic [SLOT_W-1:0] leaf_slot(input logic [RESULT_W-1:0] word);
    logic [ID_W-1:0] id;
    id = leaf_id(word);
    return id[SLOT_W-1:0];
  endfunction

  function automatic logic id_in_range(input logic [RESULT_W-1:0] word);
    return leaf_id(word) < ID_W'(DEPTH);
  endfunction

endpackage

// File: rtl/lowest_set_idx.sv
// Priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_set_idx #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top so the lowest set bit is the last assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bits[i]) idx = W'(i);
    end
  end

  assign any = |bits;

endmodule

// File: rtl/leaf_result_drain.sv
// Collects leaf results from three PE ports into ID-indexed slots, then
// streams them out in ascending ID order over valid/ready.
module leaf_result_drain
  import leaf_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    expected,
  input  logic                sample_en,
  input  logic [RESULT_W-1:0] res_a,
  input  logic [RESULT_W-1:0] res_b,
  input  logic [RESULT_W-1:0] res_c,
  output logic                out_valid,
  output logic [RESULT_W-1:0] out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count,
  output logic                err_dup,
  output logic                err_range,
  output logic                err_late,
  output state_t              fsm_state
);

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // out_valid/out_data hold steady until that edge and never depend on out_ready.

  state_t              state_q;
  logic [DEPTH-1:0]    occ_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    exp_q;
  logic [RESULT_W-1:0] slot_mem [DEPTH];

  logic [RESULT_W-1:0] res [3];
  logic [SLOT_W-1:0]   slot [3];
  logic [2:0]          wr;
  logic [DEPTH-1:0]    occ_col;
  logic [1:0]          n_add;
  logic                dup_hit;
  logic                rng_hit;
  logic                late_hit;
  logic [CNT_W-1:0]    count_col;
  logic [SLOT_W-1:0]   sel_idx;
  logic                sel_any;

  assign res[0] = res_a;
  assign res[1] = res_b;
  assign res[2] = res_c;

  // Ports resolve in order a, b, c against a running occupancy so that a
  // same-cycle collision with a higher-priority port counts as a duplicate.
  always_comb begin
    occ_col = occ_q;
    wr      = '0;
    n_add   = '0;
    dup_hit = 1'b0;
    rng_hit = 1'b0;
    for (int p = 0; p < 3; p++) begin
      slot[p] = leaf_slot(res[p]);
      if (state_q == S_COLLECT && sample_en && res[p] != '0) begin
        if (!id_in_range(res[p])) begin
          rng_hit = 1'b1;
        end else if (occ_col[slot[p]]) begin
          dup_hit = 1'b1;
        end else begin
          occ_col[slot[p]] = 1'b1;
          wr[p]            = 1'b1;
          n_add            = n_add + 2'd1;
        end
      end
    end
  end

  assign count_col = count_q + CNT_W'(n_add);
  assign late_hit  = sample_en && (state_q != S_COLLECT) &&
                     ((|res_a) || (|res_b) || (|res_c));

  lowest_set_idx #(.N(DEPTH), .W(SLOT_W)) u_sel (
    .bits (occ_q),
    .idx  (sel_idx),
    .any  (sel_any)
  );

  assign out_valid = (state_q == S_DRAIN) && sel_any;
  assign out_data  = out_valid ? slot_mem[sel_idx] : '0;
  assign out_last  = out_valid &&
                     ((occ_q & (occ_q - {{(DEPTH-1){1'b0}}, 1'b1})) == '0);
  assign busy      = (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign count     = count_q;
  assign fsm_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      occ_q     <= '0;
      count_q   <= '0;
      exp_q     <= '0;
      err_dup   <= 1'b0;
      err_range <= 1'b0;
      err_late  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            occ_q     <= '0;
            count_q   <= '0;
            exp_q     <= expected;
            err_dup   <= 1'b0;
            err_range <= 1'b0;
            err_late  <= 1'b0;
            state_q   <= (expected == '0) ? S_DRAIN : S_COLLECT;
          end
        end
        S_COLLECT: begin
          occ_q   <= occ_col;
          count_q <= count_col;
          if (dup_hit) err_dup <= 1'b1;
          if (rng_hit) err_range <= 1'b1;
          if (count_col >= exp_q) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!sel_any) begin
            state_q <= S_DONE;
          end else if (out_ready) begin
            occ_q[sel_idx] <= 1'b0;
            count_q        <= count_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A late sample in IDLE/DONE still flags even on the start edge.
      if (late_hit) err_late <= 1'b1;
    end
  end

  // Slot storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 3; p++) begin
      if (wr[p]) slot_mem[slot[p]] <= res[p];
    end
  end

endmodule

// File: tb/tb_leaf_result_drain.sv
// Directed bench for leaf_result_drain: collection, duplicate/range/late
// errors, ordered drain with backpressure, and reset mid-drain.
module tb_leaf_result_drain;
  import leaf_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [CNT_W-1:0]    expected;
  logic                sample_en;
  logic [RESULT_W-1:0] res_a, res_b, res_c;
  logic                out_valid;
  logic [RESULT_W-1:0] out_data;
  logic                out_last;
  logic                out_ready;
  logic                busy, done;
  logic [CNT_W-1:0]    count;
  logic                err_dup, err_range, err_late;
  state_t              fsm_state;

  int vectors = 0;
  int miscompares = 0;

  leaf_result_drain dut (
    .clk(clk), .reset(reset), .start(start), .expected(expected),
    .sample_en(sample_en), .res_a(res_a), .res_b(res_b), .res_c(res_c),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done), .count(count),
    .err_dup(err_dup), .err_range(err_range), .err_late(err_late),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  function automatic logic [RESULT_W-1:0] mk(input int id, input logic [31:0] payload);
    return {ID_W'(id), payload};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; sample_en = 1'b0;
    res_a = '0; res_b = '0; res_c = '0;
  endtask

  task automatic do_start(input int exp_n);
    start = 1'b1; expected = CNT_W'(exp_n);
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input logic [RESULT_W-1:0] a, input logic [RESULT_W-1:0] b,
                        input logic [RESULT_W-1:0] c);
    sample_en = 1'b1; res_a = a; res_b = b; res_c = c;
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic beat(input string tag, input logic [RESULT_W-1:0] d, input logic last);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, 64'(out_data), 64'(d));
    chk({tag, "_last"}, 64'(out_last), 64'(last));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 6) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b0; expected = '0; out_ready = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_errs", 64'({err_dup, err_range, err_late}), 64'd0);
    chk("rst_state", 64'(fsm_state), 64'(S_IDLE));
    reset = 1'b1;
    tick();

    // Three leaves in one step, drained in ascending ID order.
    do_start(3);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_state", 64'(fsm_state), 64'(S_COLLECT));
    sample(mk(7, 32'h1111), mk(2, 32'h2222), mk(30, 32'h3333));
    chk("t1_count", 64'(count), 64'd3);
    beat("t1_b0", mk(2, 32'h2222), 1'b0);
    tick(); beat("t1_b1", mk(7, 32'h1111), 1'b0);
    tick(); beat("t1_b2", mk(30, 32'h3333), 1'b1);
    tick();
    wait_done("t1");

    // Same-cycle duplicate: port a wins.
    do_start(2);
    sample(mk(5, 32'hAAAA), mk(5, 32'hBBBB), '0);
    chk("t2_dup", 64'(err_dup), 64'd1);
    chk("t2_count", 64'(count), 64'd1);
    chk("t2_state", 64'(fsm_state), 64'(S_COLLECT));
    chk("t2_novalid", 64'(out_valid), 64'd0);
    sample(mk(9, 32'h9999), '0, '0);
    beat("t2_b0", mk(5, 32'hAAAA), 1'b0);
    tick(); beat("t2_b1", mk(9, 32'h9999), 1'b1);
    tick();
    wait_done("t2");
    chk("t2_dup_sticky", 64'(err_dup), 64'd1);

    // Out-of-range ID dropped, then a single in-range leaf.
    do_start(1);
    chk("t3_dup_clr", 64'(err_dup), 64'd0);
    sample('0, '0, mk(40, 32'h4040));
    chk("t3_range", 64'(err_range), 64'd1);
    chk("t3_count", 64'(count), 64'd0);
    chk("t3_state", 64'(fsm_state), 64'(S_COLLECT));
    sample(mk(3, 32'h0303), '0, '0);
    beat("t3_b0", mk(3, 32'h0303), 1'b1);
    tick();
    wait_done("t3");

    // Backpressure: beat held for four cycles, then resumes.
    out_ready = 1'b0;
    do_start(3);
    sample(mk(6, 32'h6666), mk(1, 32'h0101), mk(4, 32'h4444));
    for (int i = 0; i < 4; i++) begin
      beat("t4_hold", mk(1, 32'h0101), 1'b0);
      chk("t4_hold_count", 64'(count), 64'd3);
      tick();
    end
    out_ready = 1'b1;
    #1;
    beat("t4_b0", mk(1, 32'h0101), 1'b0);
    tick(); beat("t4_b1", mk(4, 32'h4444), 1'b0);
    tick(); beat("t4_b2", mk(6, 32'h6666), 1'b1);
    tick();
    wait_done("t4");

    // expected==0 goes straight through DRAIN with no beats; late sample flags.
    do_start(0);
    chk("t5_state", 64'(fsm_state), 64'(S_DRAIN));
    chk("t5_novalid", 64'(out_valid), 64'd0);
    tick();
    chk("t5_novalid2", 64'(out_valid), 64'd0);
    chk("t5_done", 64'(done), 64'd1);
    sample(mk(2, 32'h1), '0, '0);
    chk("t5_late", 64'(err_late), 64'd1);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_still_done", 64'(done), 64'd1);

    // Reset after one of three beats; restart must see no stale slots.
    do_start(3);
    chk("t6_late_clr", 64'(err_late), 64'd0);
    sample(mk(10, 32'hA0), mk(11, 32'hB0), mk(12, 32'hC0));
    beat("t6_b0", mk(10, 32'hA0), 1'b0);
    tick();
    beat("t6_b1", mk(11, 32'hB0), 1'b0);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_data", 64'(out_data), 64'd0);
    chk("t6_rst_last", 64'(out_last), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_count", 64'(count), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    do_start(1);
    sample(mk(20, 32'h2020), '0, '0);
    chk("t6_count", 64'(count), 64'd1);
    beat("t6_new", mk(20, 32'h2020), 1'b1);
    tick();
    wait_done("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule
